// File: rtl/clk_period_meter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// clk_period_meter_pkg -- state encoding and parameter defaults shared by the period meter.
// Revision 1.0
package clk_period_meter_pkg;

  localparam int DEF_CNT_WIDTH = 28;
  localparam int DEF_TIMEOUT   = 1000;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ARM  = 3'd1;
  localparam logic [2:0] ST_HIGH = 3'd2;
  localparam logic [2:0] ST_LOW  = 3'd3;
  localparam logic [2:0] ST_LOS  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/clk_period_meter_if.sv
`timescale 1ns/1ps
`default_nettype none
// clk_period_meter_if -- measured signal plus measurement results of the period meter.
// Revision 1.0
interface clk_period_meter_if
  import clk_period_meter_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) ();

  logic                 sig_in;
  logic [CNT_WIDTH-1:0] period;
  logic [CNT_WIDTH-1:0] high_time;
  logic                 meas_valid;
  logic                 locked;
  logic                 timeout;

  // master: the side that supplies the slow clock and consumes the results
  modport master (
    output sig_in,
    input  period,
    input  high_time,
    input  meas_valid,
    input  locked,
    input  timeout
  );

  // slave: the meter itself
  modport slave (
    input  sig_in,
    output period,
    output high_time,
    output meas_valid,
    output locked,
    output timeout
  );

endinterface
`default_nettype wire

// File: rtl/clk_period_meter_sync_edge_det.sv
`timescale 1ns/1ps
`default_nettype none
// clk_period_meter_sync_edge_det -- two-flop synchronizer with edge register; reusable for buttons.
// Revision 1.0
module clk_period_meter_sync_edge_det (
  input  wire logic clock_in,
  input  wire logic reset_n,
  input  wire logic din,
  output logic      level,
  output logic      rise,
  output logic      fall,
  output logic      primed
);

  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] fill;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      fill <= 2'b00;
    end else begin
      s1   <= din;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[0], 1'b1};
    end
  end

  // level only reflects the real input once the reset zeros have left s1/s2
  assign primed = fill[1];
  assign level  = s2;
  assign rise   = s2 & ~s3;
  assign fall   = ~s2 & s3;

endmodule
`default_nettype wire

// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
`default_nettype none
// clk_period_meter -- measures period and high time of a slow clock, flags lock and loss-of-signal.
// Revision 1.0
module clk_period_meter
  import clk_period_meter_pkg::*;
#(
  parameter int                   CNT_WIDTH = DEF_CNT_WIDTH,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT   = CNT_WIDTH'(DEF_TIMEOUT)
) (
  input  wire logic          clock_in,
  input  wire logic          reset_n,
  clk_period_meter_if.slave  meter
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 level;
  logic                 rise;
  logic                 fall;
  logic                 primed;

  logic [2:0]           state;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH-1:0] count_inc;
  logic [CNT_WIDTH-1:0] hi_lat;
  logic [CNT_WIDTH-1:0] prev_period;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] high_q;
  logic                 meas_valid_q;
  logic                 locked_q;
  logic                 timeout_q;
  logic                 expired;

  clk_period_meter_sync_edge_det u_sync (
    .clock_in (clock_in),
    .reset_n  (reset_n),
    .din      (meter.sig_in),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .primed   (primed)
  );

  assign count_inc = (count == CNT_MAX) ? count : count + CNT_ONE;
  // >= rather than == so a fall taken exactly at the limit still times out in LOW
  assign expired   = (count >= TIMEOUT);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      count        <= '0;
      hi_lat       <= '0;
      prev_period  <= '0;
      period_q     <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (primed && !level) begin
            state <= ST_ARM;
          end
        end

        ST_ARM: begin
          if (rise) begin
            count <= CNT_ONE;
            state <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          count <= count_inc;
          if (fall) begin
            hi_lat <= count;
            state  <= ST_LOW;
          end else if (expired) begin
            state       <= ST_LOS;
            timeout_q   <= 1'b1;
            locked_q    <= 1'b0;
            prev_period <= '0;
          end
        end

        ST_LOW: begin
          count <= count_inc;
          if (rise) begin
            period_q     <= count;
            high_q       <= hi_lat;
            meas_valid_q <= 1'b1;
            locked_q     <= (count == prev_period);
            prev_period  <= count;
            count        <= CNT_ONE;
            state        <= ST_HIGH;
          end else if (expired) begin
            state       <= ST_LOS;
            timeout_q   <= 1'b1;
            locked_q    <= 1'b0;
            prev_period <= '0;
          end
        end

        ST_LOS: begin
          if (rise) begin
            timeout_q <= 1'b0;
            count     <= CNT_ONE;
            state     <= ST_HIGH;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign meter.period     = period_q;
  assign meter.high_time  = high_q;
  assign meter.meas_valid = meas_valid_q;
  assign meter.locked     = locked_q;
  assign meter.timeout    = timeout_q;

endmodule
`default_nettype wire
